facto_engine_param: RTL and testbench
=====================================

Name: facto_engine_param

Overview:
- Parametrised iterative factorial / falling-factorial (nPk) engine with an embedded radix-2 shift-add multiplier.
- Successor to the fixed 64-bit factorial controller: generic WIDTH, second mode, sticky overflow flag, busy/done handshake, and abort via opclear.
- Sits behind the bus-slave register file.
  - Register file drives opstart, opclear, mode and the operands.
  - Register file reads back result_h, result_l, opdone and overflow.

Parameters:
- WIDTH, 64, operand width and width of each result half. Full result is 2*WIDTH bits.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opstart  in  1  start pulse; sampled only in IDLE
- opclear  in  1  synchronous abort/clear; priority over opstart
- mode  in  1  0 = n!, 1 = nPk = n*(n-1)*...*(n-k+1)
- operand_n  in  WIDTH  n
- operand_k  in  WIDTH  k (mode 1 only)
- busy  out  1  high from LOAD through the last DEC
- opdone  out  1  result valid; held until opclear or a new opstart
- overflow  out  1  sticky; some intermediate product exceeded 2*WIDTH bits
- result_h  out  WIDTH  result bits [2W-1:W]
- result_l  out  WIDTH  result bits [W-1:0]

Behaviour:
- Reset (asynchronous) and opclear (synchronous):
  - state = IDLE; busy = 0, opdone = 0, overflow = 0.
  - result_h = 0, result_l = 1 (empty product).
  - opclear acts in any state, including mid-multiply. It wins over a simultaneous opstart.
- States and transitions:
  - IDLE
    - opstart = 1 → LOAD.
    - Latches n, k, mode; clears opdone and overflow.
  - LOAD
    - acc = 1.
    - fac = n.
    - rem = n-1 if mode 0 and n ≥ 2; 0 if mode 0 and n < 2; k if mode 1.
    - mode 1 with k > n → acc = 0, go to DONE.
    - rem == 0 → DONE.
    - otherwise → MUL.
  - MUL
    - Exactly WIDTH cycles: one multiplier bit of fac per cycle, LSB first.
    - Partial product: 3*WIDTH bits.
    - At the end, acc = low 2*WIDTH bits.
    - Any nonzero bit in the upper WIDTH bits sets overflow (sticky).
    - → DEC.
  - DEC
    - fac = fac-1, rem = rem-1.
    - rem becomes 0 → DONE; otherwise → MUL.
  - DONE
    - result = acc; opdone = 1; busy = 0.
    - opstart = 1 → LOAD (restart); otherwise stay.
- opstart while busy is ignored. Mode and operand changes while busy are ignored (latched copies are used).
- Latency:
  - opstart sampled at edge E0.
  - opdone is high after edge E0 + 2 + m*(WIDTH+1).
  - m = number of multiplies: n-1 for mode 0 with n ≥ 2; k for mode 1 with k ≤ n; 0 otherwise.
- result_h/result_l update only on entry to DONE, reset, or opclear. They hold the old value while busy.
- Arithmetic is unsigned. Without the optional feature, overflowing results wrap modulo 2^(2W).

Optional Feature:
- FACTO_SAT_EN defined:
  - When overflow is set at the end of a MUL, skip the remaining factors and go directly to DONE.
  - result_h = result_l = all ones; overflow = 1.
  - Latency is reduced accordingly.
- FACTO_SAT_EN undefined:
  - Computation runs all m multiplies.
  - Result is wrapped modulo 2^(2W); overflow is sticky.

Test Plan (WIDTH = 8):
- mode 0, n = 5, pulse opstart → opdone at E0+38; result_h = 0x00, result_l = 0x78; overflow = 0; busy high for 37 cycles.
- mode 0, n = 0 and n = 1 → opdone at E0+2; result = 0x0001. Then mode 0, n = 8 → result_h = 0x9D, result_l = 0x80, overflow = 0.
- mode 1 cases:
  - n = 6, k = 3 → result 0x0078 at E0+29.
  - n = 3, k = 5 → result 0x0000 at E0+2.
  - n = 7, k = 0 → result 0x0001.
- mode 0, n = 10:
  - Without FACTO_SAT_EN → result_h = 0x5F, result_l = 0x00, overflow = 1.
  - With FACTO_SAT_EN → result = 0xFFFF, overflow = 1, opdone earlier than E0+83.
- Abort and restart:
  - n = 6; assert opclear 15 cycles after start → next cycle IDLE, busy = 0, opdone = 0, result = 0x0001.
  - opstart + opclear in the same cycle → stays IDLE.
- Interference and reset:
  - opstart pulses and operand changes while busy (n = 4) → ignored; result 0x0018.
  - Assert reset asynchronously mid-MUL → all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/facto_engine_param.sv
// facto_engine_param: iterative n! / nPk engine with a radix-2 shift-add multiplier.
// Optional macro FACTO_SAT_EN: saturate to all ones and stop at the first overflow.
`default_nettype none

module facto_engine_param #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             opstart,
  input  logic             opclear,
  input  logic             mode,
  input  logic [WIDTH-1:0] operand_n,
  input  logic [WIDTH-1:0] operand_k,
  output logic             busy,
  output logic             opdone,
  output logic             overflow,
  output logic [WIDTH-1:0] result_h,
  output logic [WIDTH-1:0] result_l
);

  localparam int AW = 2 * WIDTH;
  localparam int PW = 3 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef FACTO_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MUL  = 3'd2,
    S_DEC  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state, w_next;
  logic             r_mode;
  logic [WIDTH-1:0] r_n, r_k, r_fac, r_rem, r_mplier;
  logic [AW-1:0]    r_acc, r_result;
  logic [PW-1:0]    r_prod, r_mcand;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf, r_done;

  logic [PW-1:0]    w_prod_nxt;
  logic             w_mul_last, w_mul_ovf, w_k_gt_n;
  logic [WIDTH-1:0] w_load_rem;

  assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : {PW{1'b0}});
  assign w_mul_last = (r_cnt == CW'(WIDTH - 1));
  assign w_mul_ovf  = |w_prod_nxt[PW-1:AW];
  assign w_k_gt_n   = r_mode && (r_k > r_n);
  assign w_load_rem = r_mode ? r_k :
                      (r_n >= WIDTH'(2)) ? (r_n - WIDTH'(1)) : {WIDTH{1'b0}};

  assign busy     = (r_state == S_LOAD) || (r_state == S_MUL) || (r_state == S_DEC);
  assign opdone   = r_done;
  assign overflow = r_ovf;
  assign result_h = r_result[AW-1:WIDTH];
  assign result_l = r_result[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (opstart) w_next = S_LOAD;
      S_LOAD: begin
        if (w_k_gt_n || (w_load_rem == {WIDTH{1'b0}})) w_next = S_DONE;
        else                                           w_next = S_MUL;
      end
      S_MUL: begin
        if (w_mul_last) w_next = (SAT_EN && w_mul_ovf) ? S_DONE : S_DEC;
      end
      // rem is about to reach zero when it is currently one
      S_DEC:  w_next = (r_rem == WIDTH'(1)) ? S_DONE : S_MUL;
      S_DONE: if (opstart) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
    if (opclear) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode   <= 1'b0;
      r_n      <= '0;
      r_k      <= '0;
      r_fac    <= '0;
      r_rem    <= '0;
      r_mplier <= '0;
      r_acc    <= AW'(1);
      r_result <= AW'(1);
      r_prod   <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else if (opclear) begin
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_result <= AW'(1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (opstart) begin
            r_mode <= mode;
            r_n    <= operand_n;
            r_k    <= operand_k;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
          end
        end
        S_LOAD: begin
          r_acc    <= w_k_gt_n ? {AW{1'b0}} : AW'(1);
          r_fac    <= r_n;
          r_rem    <= w_load_rem;
          r_prod   <= '0;
          r_mcand  <= PW'(1);
          r_mplier <= r_n;
          r_cnt    <= '0;
        end
        S_MUL: begin
          r_prod   <= w_prod_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_mul_last) begin
            r_ovf <= r_ovf | w_mul_ovf;
            if (SAT_EN && w_mul_ovf) r_acc <= {AW{1'b1}};
            else                     r_acc <= w_prod_nxt[AW-1:0];
          end
        end
        S_DEC: begin
          r_fac    <= r_fac - WIDTH'(1);
          r_rem    <= r_rem - WIDTH'(1);
          r_prod   <= '0;
          r_mcand  <= PW'(r_acc);
          r_mplier <= r_fac - WIDTH'(1);
          r_cnt    <= '0;
        end
        S_DONE: begin
          // acc is stable here, so re-copying it every DONE cycle is harmless
          r_result <= r_acc;
          if (opstart) begin
            r_mode <= mode;
            r_n    <= operand_n;
            r_k    <= operand_k;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
          end else begin
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_facto_engine_param.sv
// Self-checking bench for facto_engine_param (WIDTH = 8) against an arithmetic reference model.
`default_nettype none

module tb_facto_engine_param;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, opstart, opclear, mode;
  logic [W-1:0] operand_n, operand_k;
  logic         busy, opdone, overflow;
  logic [W-1:0] result_h, result_l;

  int tests = 0;
  int fails = 0;
  int prev_res;

  always #5 clk = ~clk;

  facto_engine_param #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .opstart  (opstart),
    .opclear  (opclear),
    .mode     (mode),
    .operand_n(operand_n),
    .operand_k(operand_k),
    .busy     (busy),
    .opdone   (opdone),
    .overflow (overflow),
    .result_h (result_h),
    .result_l (result_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain-arithmetic model: result, overflow and opdone latency in cycles after E0.
  function automatic void model(input bit md, input int n, input int k,
                                output int res, output bit ovf, output int lat);
    longint acc = 1;
    int     cnt, m = 0;
    ovf = 1'b0;
    if (md && k > n) begin
      res = 0; lat = 2; return;
    end
    cnt = md ? k : ((n >= 2) ? n - 1 : 0);
    for (int i = 0; i < cnt; i++) begin
      acc = acc * (n - i);
      m++;
      if (acc >= 65536) begin
        ovf = 1'b1;
        acc = acc % 65536;
`ifdef FACTO_SAT_EN
        res = 65535; lat = 1 + m * (W + 1); return;
`endif
      end
    end
    res = int'(acc);
    lat = 2 + m * (W + 1);
  endfunction

  task automatic run(input bit md, input int n, input int k, input bit interfere, input string tag);
    int eres, elat, c, bcnt;
    bit eovf, got;
    model(md, n, k, eres, eovf, elat);
    @(negedge clk);
    mode = md; operand_n = W'(n); operand_k = W'(k); opstart = 1'b1;
    @(posedge clk); #1;
    opstart = 1'b0;
    chk({tag, "_hold"}, {16'h0, result_h, result_l}, prev_res);
    bcnt = busy; c = 0; got = 1'b0;
    while (!got && c < 400) begin
      if (interfere && busy) begin
        opstart = 1'($urandom_range(0, 1));
        operand_n = W'($urandom); operand_k = W'($urandom); mode = 1'($urandom);
      end else begin
        opstart = 1'b0;
      end
      @(posedge clk); #1;
      c++;
      if (opdone) got = 1'b1;
      else        bcnt += busy;
    end
    chk({tag, "_lat"},  c, elat);
    chk({tag, "_busy"}, bcnt, elat - 1);
    chk({tag, "_res"},  {16'h0, result_h, result_l}, eres);
    chk({tag, "_ovf"},  {31'h0, overflow}, {31'h0, eovf});
    @(posedge clk); #1;
    chk({tag, "_held"}, {15'h0, opdone, result_h, result_l}, {15'h0, 1'b1, eres[15:0]});
    prev_res = eres;
  endtask

  initial begin
    int rn, rk;
    bit rm;
    reset = 1'b1; opstart = 1'b0; opclear = 1'b0; mode = 1'b0;
    operand_n = '0; operand_k = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vals", {13'h0, busy, opdone, overflow, result_h, result_l}, 32'h0001);
    @(negedge clk); reset = 1'b0;
    prev_res = 1;

    run(0, 5, 0, 0, "fact5");
    run(0, 0, 0, 0, "fact0");
    run(0, 1, 0, 0, "fact1");
    run(0, 8, 0, 0, "fact8");
    run(1, 6, 3, 0, "p6_3");
    run(1, 3, 5, 0, "p3_5");
    run(1, 7, 0, 0, "p7_0");
    run(0, 10, 0, 0, "fact10");
    run(0, 4, 0, 1, "interf4");

    // abort mid-computation
    @(negedge clk); mode = 1'b0; operand_n = W'(6); opstart = 1'b1;
    @(posedge clk); #1; opstart = 1'b0;
    repeat (14) @(posedge clk);
    #1; opclear = 1'b1;
    @(posedge clk); #1; opclear = 1'b0;
    chk("abort", {13'h0, busy, opdone, overflow, result_h, result_l}, 32'h0001);
    @(posedge clk); #1;
    chk("abort_idle", {31'h0, busy}, 0);
    prev_res = 1;

    // opclear beats a simultaneous opstart
    @(negedge clk); opstart = 1'b1; opclear = 1'b1;
    @(posedge clk); #1; opstart = 1'b0; opclear = 1'b0;
    chk("clr_vs_start", {30'h0, busy, opdone}, 0);
    @(posedge clk); #1;
    chk("clr_vs_start2", {13'h0, busy, opdone, overflow, result_h, result_l}, 32'h0001);

    run(0, 6, 0, 0, "fact6");

    // asynchronous reset mid-multiply
    @(negedge clk); operand_n = W'(5); mode = 1'b0; opstart = 1'b1;
    @(posedge clk); #1; opstart = 1'b0;
    repeat (5) @(posedge clk);
    #3; reset = 1'b1;
    #1;
    chk("async_rst", {13'h0, busy, opdone, overflow, result_h, result_l}, 32'h0001);
    @(negedge clk); reset = 1'b0;
    prev_res = 1;

    for (int i = 0; i < 20; i++) begin
      rm = 1'($urandom_range(0, 1));
      rn = int'($urandom_range(0, 14));
      rk = int'($urandom_range(0, rn + 2));
      run(rm, rn, rk, 1'($urandom_range(0, 1)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
